bp_be_pipe_int_staged: RTL and testbench

Parametrised integer execution pipe for the BlackParrot backend. It computes integer ALU results, jump link values, and branch targets, then carries them through a configurable number of retiming stages. Along the way it adds per-stage valid tracking, stall, flush, and mispredict detection against the fetched next-PC. It sits in the calculator beside the memory and FP pipes, and replaces the single-cycle combinational integer pipe where timing closure needs registered results.

---
 rtl/bp_be_pipe_int_staged_pkg.sv | 44 ++++
 rtl/bp_be_int_alu.sv | 51 +++++
 rtl/bp_be_pipe_int_stage_reg.sv | 22 ++
 rtl/bp_be_pipe_int_staged.sv | 117 +++++++++++
 tb/tb_bp_be_pipe_int_staged.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pipe_int_staged_pkg.sv
// Shared types for the staged integer pipe: ALU op codes, result select and the decode bundle.
package bp_be_pipe_int_staged_pkg;

    typedef enum logic [3:0] {
        e_op_add  = 4'd0,
        e_op_sub  = 4'd1,
        e_op_sll  = 4'd2,
        e_op_slt  = 4'd3,
        e_op_sltu = 4'd4,
        e_op_xor  = 4'd5,
        e_op_srl  = 4'd6,
        e_op_sra  = 4'd7,
        e_op_or   = 4'd8,
        e_op_and  = 4'd9,
        e_op_eq   = 4'd10,
        e_op_ne   = 4'd11,
        e_op_lt   = 4'd12,
        e_op_ge   = 4'd13,
        e_op_ltu  = 4'd14,
        e_op_geu  = 4'd15
    } bp_be_fu_op_e;

    // The FP encoding is kept so decode stays compatible; this pipe returns the ALU result for it.
    typedef enum logic [1:0] {
        e_result_alu = 2'd0,
        e_result_pc4 = 2'd1,
        e_result_fp  = 2'd2
    } bp_be_result_sel_e;

    typedef struct packed {
        bp_be_fu_op_e      fu_op;
        logic              opw_v;
        logic              src1_sel;
        logic              src2_sel;
        logic              baddr_sel;
        bp_be_result_sel_e result_sel;
        logic              br_v;
        logic              jmp_v;
        logic              pipe_int_v;
    } bp_be_decode_s;

    localparam int bp_be_decode_width_gp = $bits(bp_be_decode_s);

endpackage

// File: rtl/bp_be_int_alu.sv
// Integer ALU for stage 0; opw_v ops compute on the low word and sign-extend the 32-bit result.
module bp_be_int_alu
    import bp_be_pipe_int_staged_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic [width_p-1:0] src1,
    input  logic [width_p-1:0] src2,
    input  bp_be_fu_op_e       fu_op,
    input  logic               opw_v,
    output logic [width_p-1:0] result
);
    localparam int shamt_width_lp = $clog2(width_p);

    logic [width_p-1:0]        shift_src;
    logic [width_p-1:0]        raw;
    logic [shamt_width_lp-1:0] shamt;

    always_comb begin
        shamt     = src2[shamt_width_lp-1:0];
        shift_src = src1;
        // Word shifts must see a clean 32-bit operand so bits shifted in from above are correct.
        if (opw_v) begin
            shamt     = shamt_width_lp'(src2[4:0]);
            shift_src = (fu_op == e_op_sra) ? {{(width_p-32){src1[31]}}, src1[31:0]}
                                            : {{(width_p-32){1'b0}}, src1[31:0]};
        end

        raw = '0;
        case (fu_op)
            e_op_add:           raw = src1 + src2;
            e_op_sub:           raw = src1 - src2;
            e_op_sll:           raw = src1 << shamt;
            e_op_slt, e_op_lt:  raw = width_p'($signed(src1) < $signed(src2));
            e_op_sltu, e_op_ltu: raw = width_p'(src1 < src2);
            e_op_xor:           raw = src1 ^ src2;
            e_op_srl:           raw = shift_src >> shamt;
            e_op_sra:           raw = $unsigned($signed(shift_src) >>> shamt);
            e_op_or:            raw = src1 | src2;
            e_op_and:           raw = src1 & src2;
            e_op_eq:            raw = width_p'(src1 == src2);
            e_op_ne:            raw = width_p'(src1 != src2);
            e_op_ge:            raw = width_p'(!($signed(src1) < $signed(src2)));
            e_op_geu:           raw = width_p'(!(src1 < src2));
            default:            raw = '0;
        endcase

        result = opw_v ? {{(width_p-32){raw[31]}}, raw[31:0]} : raw;
    end

endmodule

// File: rtl/bp_be_pipe_int_stage_reg.sv
// One retiming stage of the integer pipe. The record's MSB is its valid bit; flush clears only that bit.
module bp_be_pipe_int_stage_reg #(
    parameter int width_p = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic               flush,
    input  logic [width_p-1:0] d,
    output logic [width_p-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q <= '0;
        end else if (flush) begin
            q[width_p-1] <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bp_be_pipe_int_staged.sv
// Integer execution pipe: stage-0 ALU/branch resolve, then latency_p registered stages with stall/flush.
// Defining BP_BE_PIPE_INT_FWD_EN adds the fwd_* per-stage bypass taps.
module bp_be_pipe_int_staged
    import bp_be_pipe_int_staged_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int dword_width_p = 64,
    parameter int instr_width_p = 32,
    parameter int latency_p     = 2,
    parameter int tag_width_p   = 5
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             v_i,
    output logic                             ready_o,
    input  logic [bp_be_decode_width_gp-1:0] decode_i,
    input  logic [instr_width_p-1:0]         instr_i,
    input  logic [vaddr_width_p-1:0]         pc_i,
    input  logic [dword_width_p-1:0]         rs1_i,
    input  logic [dword_width_p-1:0]         rs2_i,
    input  logic [dword_width_p-1:0]         imm_i,
    input  logic [tag_width_p-1:0]           tag_i,
    input  logic [vaddr_width_p-1:0]         npc_i,
    input  logic                             stall_i,
    input  logic                             flush_i,
    output logic                             v_o,
    output logic [dword_width_p-1:0]         data_o,
    output logic [tag_width_p-1:0]           tag_o,
    output logic [vaddr_width_p-1:0]         br_tgt_o,
    output logic                             mispredict_o
`ifdef BP_BE_PIPE_INT_FWD_EN
    ,
    output logic [latency_p-1:0]             fwd_v_o,
    output logic [latency_p*tag_width_p-1:0] fwd_tag_o,
    output logic [latency_p*dword_width_p-1:0] fwd_data_o
`endif
);
    // v must stay first: the stage register treats the MSB as the valid bit.
    typedef struct packed {
        logic                     v;
        logic [tag_width_p-1:0]   tag;
        logic [dword_width_p-1:0] data;
        logic [vaddr_width_p-1:0] br_tgt;
        logic                     mispredict;
    } bp_be_pipe_int_stage_s;

    localparam int stage_width_lp = $bits(bp_be_pipe_int_stage_s);

    bp_be_decode_s            decode;
    logic [dword_width_p-1:0] pc_sext, pc4, src1, src2, baddr, tgt_full, alu_result;
    logic [vaddr_width_p-1:0] br_tgt;
    logic                     btaken;
    bp_be_pipe_int_stage_s    issue_rec, final_rec;
    logic [latency_p:0][stage_width_lp-1:0] chain;

    assign decode   = decode_i;
    assign pc_sext  = {{(dword_width_p-vaddr_width_p){pc_i[vaddr_width_p-1]}}, pc_i};
    assign pc4      = pc_sext + dword_width_p'(4);
    assign src1     = decode.src1_sel  ? pc_sext : rs1_i;
    assign src2     = decode.src2_sel  ? imm_i   : rs2_i;
    assign baddr    = decode.baddr_sel ? src1    : pc_sext;
    assign tgt_full = baddr + imm_i;

    bp_be_int_alu #(.width_p(dword_width_p)) alu (
        .src1   (src1),
        .src2   (src2),
        .fu_op  (decode.fu_op),
        .opw_v  (decode.opw_v),
        .result (alu_result)
    );

    assign btaken = (decode.br_v & alu_result[0]) | decode.jmp_v;
    assign br_tgt = (decode.pipe_int_v & btaken) ? tgt_full[vaddr_width_p-1:0]
                                                 : pc4[vaddr_width_p-1:0];

    assign issue_rec.v          = v_i & ~stall_i & ~flush_i;
    assign issue_rec.tag        = tag_i;
    assign issue_rec.data       = (decode.result_sel == e_result_pc4) ? pc4 : alu_result;
    assign issue_rec.br_tgt     = br_tgt;
    assign issue_rec.mispredict = (br_tgt != npc_i);

    assign chain[0] = issue_rec;

    for (genvar i = 1; i <= latency_p; i++) begin : g_stage
        bp_be_pipe_int_stage_reg #(.width_p(stage_width_lp)) stage_reg (
            .clk   (clk_i),
            .rst_b (reset_i),
            .en    (~stall_i),
            .flush (flush_i),
            .d     (chain[i-1]),
            .q     (chain[i])
        );
    end

    assign final_rec    = chain[latency_p];
    assign ready_o      = ~stall_i;
    assign v_o          = final_rec.v;
    assign data_o       = final_rec.data;
    assign tag_o        = final_rec.tag;
    assign br_tgt_o     = final_rec.br_tgt;
    assign mispredict_o = final_rec.v & final_rec.mispredict;

`ifdef BP_BE_PIPE_INT_FWD_EN
    for (genvar i = 0; i < latency_p; i++) begin : g_fwd
        bp_be_pipe_int_stage_s tap;
        assign tap = chain[i+1];
        assign fwd_v_o[i]                                 = tap.v;
        assign fwd_tag_o[i*tag_width_p +: tag_width_p]     = tap.tag;
        assign fwd_data_o[i*dword_width_p +: dword_width_p] = tap.data;
    end
`endif

    // Raw instruction and target carry-out are not needed by this pipe.
    logic unused_bits;
    assign unused_bits = ^{instr_i, tgt_full[dword_width_p-1:vaddr_width_p]};

endmodule

// File: tb/tb_bp_be_pipe_int_staged.sv
// Scoreboard bench for bp_be_pipe_int_staged: directed ops, stall, flush and mid-flight reset.
module tb_bp_be_pipe_int_staged;
    import bp_be_pipe_int_staged_pkg::*;

    localparam int LAT = 2;
    localparam int VW  = 39;
    localparam int DW  = 64;
    localparam int TW  = 5;
    localparam int IW  = 32;

    logic                             clk_i = 1'b0;
    logic                             reset_i;
    logic                             v_i;
    logic                             ready_o;
    bp_be_decode_s                    decode_i;
    logic [IW-1:0]                    instr_i;
    logic [VW-1:0]                    pc_i, npc_i, br_tgt_o;
    logic [DW-1:0]                    rs1_i, rs2_i, imm_i, data_o;
    logic [TW-1:0]                    tag_i, tag_o;
    logic                             stall_i, flush_i, v_o, mispredict_o;
`ifdef BP_BE_PIPE_INT_FWD_EN
    logic [LAT-1:0]                   fwd_v_o;
    logic [LAT*TW-1:0]                fwd_tag_o;
    logic [LAT*DW-1:0]                fwd_data_o;
`endif

    bp_be_pipe_int_staged #(
        .vaddr_width_p(VW), .dword_width_p(DW), .instr_width_p(IW),
        .latency_p(LAT), .tag_width_p(TW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .decode_i(decode_i), .instr_i(instr_i), .pc_i(pc_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .tag_i(tag_i), .npc_i(npc_i),
        .stall_i(stall_i), .flush_i(flush_i), .v_o(v_o), .data_o(data_o),
        .tag_o(tag_o), .br_tgt_o(br_tgt_o), .mispredict_o(mispredict_o)
`ifdef BP_BE_PIPE_INT_FWD_EN
        , .fwd_v_o(fwd_v_o), .fwd_tag_o(fwd_tag_o), .fwd_data_o(fwd_data_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [VW-1:0] tgt;
        logic          misp;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid result must match the oldest expected entry, including its arrival cycle.
    exp_t e;
    always @(negedge clk_i) begin
        if (v_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_v_o: got v_o=1 tag=%0d expected no result (cycle %0d)", tag_o, cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("data_t%0d", e.tag), data_o, e.data);
                chk($sformatf("tag_t%0d", e.tag), 64'(tag_o), 64'(e.tag));
                chk($sformatf("br_tgt_t%0d", e.tag), 64'(br_tgt_o), 64'(e.tgt));
                chk($sformatf("mispredict_t%0d", e.tag), 64'(mispredict_o), 64'(e.misp));
                chk($sformatf("arrival_cycle_t%0d", e.tag), 64'(cyc), 64'(e.at));
            end
        end
    end

    function automatic bp_be_decode_s mk(input bp_be_fu_op_e op, input logic opw, input logic s1,
                                         input logic s2, input logic bsel, input bp_be_result_sel_e rsel,
                                         input logic br, input logic jmp);
        mk = '{fu_op:op, opw_v:opw, src1_sel:s1, src2_sel:s2, baddr_sel:bsel,
               result_sel:rsel, br_v:br, jmp_v:jmp, pipe_int_v:1'b1};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bp_be_decode_s d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input logic [VW-1:0] pc, input logic [VW-1:0] np,
                         input logic [TW-1:0] tg);
        v_i = 1'b1; decode_i = d; rs1_i = a; rs2_i = b; imm_i = im;
        pc_i = pc; npc_i = np; tag_i = tg;
    endtask

    task automatic expect_res(input logic [TW-1:0] tg, input logic [DW-1:0] ed, input logic [VW-1:0] et,
                              input logic em, input int extra);
        sb.push_back('{tag:tg, data:ed, tgt:et, misp:em, at:cyc + LAT + extra});
    endtask

    task automatic issue(input bp_be_decode_s d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input logic [VW-1:0] pc, input logic [VW-1:0] np,
                         input logic [TW-1:0] tg, input logic [DW-1:0] ed, input logic [VW-1:0] et,
                         input logic em);
        drive(d, a, b, im, pc, np, tg);
        expect_res(tg, ed, et, em, 0);
    endtask

    bp_be_decode_s d_add, d_beq, d_jalr, d_addw, d_sraiw, d_sub, d_auipc, d_jal, d_fp, d_xor, d_or;

    initial begin
        d_add   = mk(e_op_add, 1'b0, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_beq   = mk(e_op_eq,  1'b0, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b1, 1'b0);
        d_jalr  = mk(e_op_add, 1'b0, 1'b0, 1'b1, 1'b1, e_result_pc4, 1'b0, 1'b1);
        d_addw  = mk(e_op_add, 1'b1, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_sraiw = mk(e_op_sra, 1'b1, 1'b0, 1'b1, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_sub   = mk(e_op_sub, 1'b0, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_auipc = mk(e_op_add, 1'b0, 1'b1, 1'b1, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_jal   = mk(e_op_add, 1'b0, 1'b1, 1'b1, 1'b0, e_result_pc4, 1'b0, 1'b1);
        d_fp    = mk(e_op_add, 1'b0, 1'b0, 1'b0, 1'b0, e_result_fp,  1'b0, 1'b0);
        d_xor   = mk(e_op_xor, 1'b0, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b0, 1'b0);
        d_or    = mk(e_op_or,  1'b0, 1'b0, 1'b0, 1'b0, e_result_alu, 1'b0, 1'b0);

        reset_i = 1'b0; v_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        decode_i = d_add; instr_i = 32'h0000_0013; pc_i = '0; npc_i = '0;
        rs1_i = '0; rs2_i = '0; imm_i = '0; tag_i = '0;
        step(); step();

        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_data_o", data_o, 64'd0);
        chk("rst_tag_o", 64'(tag_o), 64'd0);
        chk("rst_br_tgt_o", 64'(br_tgt_o), 64'd0);
        chk("rst_mispredict_o", 64'(mispredict_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
`ifdef BP_BE_PIPE_INT_FWD_EN
        chk("rst_fwd_v_o", 64'(fwd_v_o), 64'd0);
`endif
        reset_i = 1'b1;
        step();

        // Back-to-back directed ops, one per cycle.
        issue(d_add,   64'd5, 64'd7, 64'd0, 39'h100, 39'h104, 5'd1, 64'd12, 39'h104, 1'b0); step();
        issue(d_beq,   64'd3, 64'd3, 64'h20, 39'h1000, 39'h1004, 5'd2, 64'd1, 39'h1020, 1'b1); step();
        issue(d_beq,   64'd3, 64'd4, 64'h20, 39'h1000, 39'h1004, 5'd3, 64'd0, 39'h1004, 1'b0); step();
        issue(d_jalr,  64'h2001, 64'd0, 64'd4, 39'h3000, 39'h2005, 5'd4, 64'h3004, 39'h2005, 1'b0); step();
        issue(d_addw,  64'h7FFF_FFFF, 64'd1, 64'd0, 39'h4000, 39'h4004, 5'd5,
              64'hFFFF_FFFF_8000_0000, 39'h4004, 1'b0); step();
        issue(d_sraiw, 64'h8000_0000, 64'd0, 64'd4, 39'h4004, 39'h4008, 5'd6,
              64'hFFFF_FFFF_F800_0000, 39'h4008, 1'b0); step();
        issue(d_sub,   64'd3, 64'd5, 64'd0, 39'h5000, 39'h5004, 5'd7,
              64'hFFFF_FFFF_FFFF_FFFE, 39'h5004, 1'b0); step();
        issue(d_add,   64'h10, 64'h20, 64'd0, 39'h200, 39'h300, 5'd8, 64'h30, 39'h204, 1'b1); step();
        issue(d_auipc, 64'd0, 64'd0, 64'h123, 39'h7000, 39'h7004, 5'd9, 64'h7123, 39'h7004, 1'b0); step();
        issue(d_jal,   64'd0, 64'd0, 64'h10, 39'h40_0000_0000, 39'h40_0000_0010, 5'd10,
              64'hFFFF_FFC0_0000_0004, 39'h40_0000_0010, 1'b0); step();
        issue(d_fp,    64'h40, 64'd2, 64'd0, 39'h600, 39'h604, 5'd11, 64'h42, 39'h604, 1'b0); step();
        v_i = 1'b0;
        repeat (4) step();

        // Stall for three cycles right after the first of three ops.
        drive(d_add, 64'd1, 64'd2, 64'd0, 39'h100, 39'h104, 5'd12);
        expect_res(5'd12, 64'd3, 39'h104, 1'b0, 3);
        step();
        drive(d_xor, 64'hF0, 64'hFF, 64'd0, 39'h100, 39'h104, 5'd13);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ready_during_stall_%0d", i), 64'(ready_o), 64'd0);
            step();
        end
        stall_i = 1'b0;
        #1;
        chk("ready_after_stall", 64'(ready_o), 64'd1);
        expect_res(5'd13, 64'h0F, 39'h104, 1'b0, 0);
        step();
        issue(d_or, 64'hF0, 64'h0F, 64'd0, 39'h100, 39'h104, 5'd14, 64'hFF, 39'h104, 1'b0);
        step();
        v_i = 1'b0;
        repeat (5) step();

        // Flush with a stalled incoming op: both are lost; the next op flows normally.
        drive(d_add, 64'd1, 64'd1, 64'd0, 39'h100, 39'h104, 5'd15);
        step();
        drive(d_add, 64'd2, 64'd2, 64'd0, 39'h100, 39'h104, 5'd16);
        stall_i = 1'b1;
        flush_i = 1'b1;
        step();
        stall_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_v_o_slot1", 64'(v_o), 64'd0);
`ifdef BP_BE_PIPE_INT_FWD_EN
        chk("flush_fwd_v_o", 64'(fwd_v_o), 64'd0);
`endif
        issue(d_add, 64'd100, 64'd1, 64'd0, 39'h100, 39'h104, 5'd17, 64'd101, 39'h104, 1'b0);
        step();
        v_i = 1'b0;
        chk("flush_v_o_slot2", 64'(v_o), 64'd0);
        repeat (4) step();

        // Reset while an op is in flight.
        drive(d_add, 64'd7, 64'd7, 64'd0, 39'h100, 39'h104, 5'd18);
        step();
        v_i = 1'b0;
        reset_i = 1'b0;
        step();
        chk("midrst_v_o", 64'(v_o), 64'd0);
        chk("midrst_data_o", data_o, 64'd0);
        chk("midrst_tag_o", 64'(tag_o), 64'd0);
        reset_i = 1'b1;
        issue(d_add, 64'd2, 64'd3, 64'd0, 39'h100, 39'h104, 5'd19, 64'd5, 39'h104, 1'b0);
        step();
        v_i = 1'b0;

        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
